// File: rtl/ephoto_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ephoto_pkg
//  Description : Shared types and constants for the UART-to-SPRAM photo path
//                (pixel packer and frame store).
//  Revision    : 1.0 - initial release
// ============================================================================
package ephoto_pkg;

    // Pixel width shared with the frame store: RGB444.
    localparam int PIX_W = 12;

    // Default two-byte frame header.
    localparam logic [7:0] DEFAULT_HDR0 = 8'hAA;
    localparam logic [7:0] DEFAULT_HDR1 = 8'h55;

    // Packer state encoding.
    typedef enum logic [2:0] {
        PK_HUNT0 = 3'd0,
        PK_HUNT1 = 3'd1,
        PK_PAY0  = 3'd2,
        PK_PAY1  = 3'd3,
        PK_PAY2  = 3'd4
    } packer_state_e;

endpackage : ephoto_pkg
`default_nettype wire

// File: rtl/uart_pixel_packer_idle_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : idle_timeout
//  Description : Down-counter watchdog. Reloads while clr is high, counts down
//                while en is high, and raises expire combinationally in the
//                cycle the LIMIT-th consecutive idle clock is reached. A clr in
//                that same cycle suppresses expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module idle_timeout #(
    parameter  int LIMIT = 16,
    localparam int CW    = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CW-1:0] c_load = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    // Remaining idle clocks before expiry; reloaded on every clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= c_load;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expire = en & ~clr & (r_cnt == '0);

endmodule : idle_timeout
`default_nettype wire

// File: rtl/uart_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pixel_packer
//  Description : Locks onto a two-byte header in the UART byte stream, unpacks
//                RGB444 pixels packed two per three bytes and strobes them to
//                the frame store. Flags frame completion and aborts a stalled
//                frame on inter-byte timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_pixel_packer
    import ephoto_pkg::*;
#(
    parameter  int         W              = 4,
    parameter  int         H              = 2,
    parameter  int         TIMEOUT_CYCLES = 1_000_000,
    parameter  logic [7:0] HDR0           = DEFAULT_HDR0,
    parameter  logic [7:0] HDR1           = DEFAULT_HDR1,
    localparam int         PIX_TOTAL      = W * H,
    localparam int         IW             = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             rx_valid,
    output logic [PIX_W-1:0] rx_data,
    output logic [IW-1:0]    pix_index,
    output logic             frame_active,
    output logic             frame_done,
    output logic             frame_error
);

    localparam logic [2:0]    S_HUNT0  = 3'(PK_HUNT0);
    localparam logic [2:0]    S_HUNT1  = 3'(PK_HUNT1);
    localparam logic [2:0]    S_PAY0   = 3'(PK_PAY0);
    localparam logic [2:0]    S_PAY1   = 3'(PK_PAY1);
    localparam logic [2:0]    S_PAY2   = 3'(PK_PAY2);
    localparam logic [IW-1:0] c_last   = IW'(PIX_TOTAL - 1);

    logic [2:0]    r_state;
    logic [7:0]    r_b0;
    logic [3:0]    r_nib;
    logic [IW-1:0] r_pix_cnt;
    logic          w_in_pay;
    logic          w_expire;
    logic          w_is_last;

    assign w_in_pay  = (r_state == S_PAY0) | (r_state == S_PAY1) | (r_state == S_PAY2);
    assign w_is_last = (r_pix_cnt == c_last);

    // Idle watchdog: only armed inside a payload, cleared by every byte.
    idle_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (byte_valid | ~w_in_pay),
        .en     (w_in_pay),
        .expire (w_expire)
    );

    // Header hunt, payload unpacking, pixel counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HUNT0;
            r_b0         <= '0;
            r_nib        <= '0;
            r_pix_cnt    <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            pix_index    <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            // frame_active stays up through the frame_done cycle, then drops.
            if (frame_done) begin
                frame_active <= 1'b0;
            end
            if (byte_valid) begin
                case (r_state)
                    S_HUNT0: begin
                        if (byte_data == HDR0) begin
                            r_state <= S_HUNT1;
                        end
                    end
                    S_HUNT1: begin
                        if (byte_data == HDR1) begin
                            r_state      <= S_PAY0;
                            r_pix_cnt    <= '0;
                            frame_active <= 1'b1;
                        end else if (byte_data != HDR0) begin
                            r_state <= S_HUNT0;
                        end
                    end
                    S_PAY0: begin
                        r_b0    <= byte_data;
                        r_state <= S_PAY1;
                    end
                    S_PAY1: begin
                        rx_valid  <= 1'b1;
                        rx_data   <= {r_b0, byte_data[7:4]};
                        pix_index <= r_pix_cnt;
                        r_nib     <= byte_data[3:0];
                        if (w_is_last) begin
                            // Odd pixel total: low nibble is padding.
                            frame_done <= 1'b1;
                            r_pix_cnt  <= '0;
                            r_state    <= S_HUNT0;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                            r_state   <= S_PAY2;
                        end
                    end
                    S_PAY2: begin
                        rx_valid  <= 1'b1;
                        rx_data   <= {r_nib, byte_data};
                        pix_index <= r_pix_cnt;
                        if (w_is_last) begin
                            frame_done <= 1'b1;
                            r_pix_cnt  <= '0;
                            r_state    <= S_HUNT0;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                            r_state   <= S_PAY0;
                        end
                    end
                    default: begin
                        r_state <= S_HUNT0;
                    end
                endcase
            end else if (w_expire) begin
                frame_error  <= 1'b1;
                frame_active <= 1'b0;
                r_pix_cnt    <= '0;
                r_state      <= S_HUNT0;
            end
        end
    end

endmodule : uart_pixel_packer
`default_nettype wire

// File: doc/uart_pixel_packer.md
# uart_pixel_packer

Upstream stage of the SPRAM frame store. Consumes the byte stream from the UART receiver, locks onto a two-byte frame header, unpacks RGB444 pixels packed two-per-three-bytes, and presents each pixel to the frame store as a one-cycle `rx_valid`/`rx_data` strobe. Also flags frame completion and aborts a stalled frame on inter-byte timeout.

## Interface
- `W`, 4: image width in pixels.
- `H`, 2: image height in pixels.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle clocks between payload bytes before the frame is aborted (≥2).
- `HDR0`, 8'hAA: first header byte.
- `HDR1`, 8'h55: second header byte.

Derived: `PIX_TOTAL = W*H`; `IW = $clog2(PIX_TOTAL)`, minimum 1.

Ports:
- `clk` in 1: system clock. The block is single-clock.
- `rst` in 1: reset, asynchronous and active-high.
- `byte_valid` in 1: one-cycle strobe; `byte_data` is valid this cycle. May assert every cycle.
- `byte_data` in 8: received UART byte.
- `rx_valid` out 1: one-cycle pixel strobe.
- `rx_data` out 12: pixel value {R,G,B} 4:4:4. Held between strobes.
- `pix_index` out IW: index of the pixel on `rx_data` when `rx_valid` is high.
- `frame_active` out 1: high from header acceptance until frame end or abort.
- `frame_done` out 1: one-cycle pulse coincident with the last pixel's `rx_valid`.
- `frame_error` out 1: one-cycle pulse on timeout abort.

## Operation
- **States:** HUNT0, HUNT1, PAY0, PAY1, PAY2.
- **HUNT0:** on a `HDR0` byte, go to HUNT1. Any other byte is ignored.
- **HUNT1:**
  - On `HDR1`: go to PAY0, clear the pixel counter, and set `frame_active`.
  - On `HDR0`: stay in HUNT1.
  - On any other byte: return to HUNT0.
- **Packing:** pixel pair (p0,p1) occupies bytes b0,b1,b2.
  - b0 = p0[11:4].
  - b1 = {p0[3:0], p1[11:8]}.
  - b2 = p1[7:0].
- **PAY0:** latch b0 and go to PAY1. No output.
- **PAY1:** emit p0 = {b0, b1[7:4]} and latch b1[3:0].
  - If p0 is pixel `PIX_TOTAL-1` (odd `PIX_TOTAL`), the frame ends here. b1[3:0] is padding and is discarded.
  - Otherwise go to PAY2.
- **PAY2:** emit p1 = {latched nibble, b2}, then go to PAY0, or end the frame if p1 is the last pixel.
- **Frame end:**
  - Pulse `frame_done` together with the final `rx_valid`.
  - Clear `frame_active` on the next cycle.
  - Return to HUNT0 and zero the counter.
- Header bytes inside the payload are treated as data; there is no resynchronisation mid-frame.
- **Timeout:**
  - The idle counter runs only in PAY0/PAY1/PAY2 and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_error`, clear `frame_active`, go to HUNT0, and zero the pixel counter. No `frame_done` is issued.
  - If a byte arrives in the same cycle the count is reached, the byte wins: it is processed and no timeout occurs.
- **Pixel counter:**
  - IW bits wide; increments per emitted pixel.
  - Never wraps within a frame, because the frame ends at `PIX_TOTAL-1`.

## Timing
- **Latency:** `rx_valid` asserts on the clock edge after the completing `byte_valid`, i.e. 1 cycle of registered output.
- **Throughput:** at most one pixel per byte, so back-to-back `byte_valid` is sustainable with no backpressure. Downstream must accept every strobe.
- **Reset values:**
  - `rx_valid`, `frame_done`, `frame_error`, `frame_active`: 0.
  - `rx_data`: 12'h000; `pix_index`: 0.
  - State: HUNT0; idle counter: 0.
- **Reset mid-frame:** the partial frame is dropped silently, with no `frame_done` or `frame_error`.
- **Frame re-arm:** a header arriving immediately after `frame_done` is accepted. HUNT0 is active on the cycle after the last payload byte.

## Structure
- Shared package `ephoto_pkg`:
  - packer state enum;
  - `HDR0`/`HDR1` defaults;
  - `PIX_W = 12` pixel width constant, shared with the frame store.
- One sub-module is natural: `idle_timeout` (parameterised down-counter with clear/enable and an expiry pulse), which is reusable by other UART-facing blocks.
- The remaining logic (FSM, nibble latch, pixel counter, output registers) lives in `uart_pixel_packer`.

## Test plan
- **Basic frame** (W=4, H=2): bytes AA 55 12 34 56 78 9A BC DE F0 12 34 56 78.
  - Required: 8 strobes with `rx_data` = 123,456,789,ABC,DEF,012,345,678 and `pix_index` 0–7.
  - `frame_done` coincides with index 7; `frame_active` then falls.
- **Odd total** (W=3, H=1): AA 55 AB CD EF 12 3F.
  - Required: pixels ABC, DEF, 123; `frame_done` on the third pixel.
  - The 0xF nibble is ignored, and a following AA 55 starts a new frame.
- **Header hunting:** 00 AA AA 55 followed by a valid payload locks correctly. AA 00 55 does not lock, with no `frame_active`.
- **Timeout** (TIMEOUT_CYCLES=16): header, then 3 bytes, then idle.
  - Required: `frame_error` pulses exactly 16 cycles after the last byte, with `frame_active`=0 and no `frame_done`.
  - A byte on cycle 16 instead prevents the abort.
- **Back-to-back bytes:** `byte_valid` is held high for a whole frame.
  - Required: one strobe per completing byte, with no pixels lost and no duplicated indices.
- **Reset mid-frame:** assert `rst` asynchronously after pixel 2.
  - Required: all outputs are at reset values immediately, with no `frame_error`.
  - The next full frame starts at index 0.
